// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and constants for the data-RAM arbiter:
//                FSM state encoding, wait-counter width, port indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Wait counter width; holds WAIT_CYCLES up to 15
  localparam int c_CNT_W = 4;

  // Requester indices
  localparam logic c_PORT0 = 1'b0;
  localparam logic c_PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way request picker. Round-robin on a tie
//                (grants the port not granted last); with
//                MEM_ARBITER_FIXED_PRIO_EN defined, port 0 always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  // Pick one requester, one-hot
  always_comb begin
    gnt   = 2'b00;
    valid = |req;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
`else
    if (req == 2'b11) begin
      gnt = (last == c_PORT1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter/sequencer for the single-port data
//                RAM. Grants one transaction at a time, holds RAM enables for
//                WAIT_CYCLES cycles, returns registered read data and a
//                one-cycle ack. Macro MEM_ARBITER_FIXED_PRIO_EN selects fixed
//                priority (port 0 wins ties) instead of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_r_en,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0]  c_ADDR_MASK = ~ADDR_W'(3);

  // Configuration sanity check at elaboration
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range_err
    $error("mem_arbiter: WAIT_CYCLES=%0d outside legal range 1..15", WAIT_CYCLES);
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_owner;
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic [1:0]          w_gnt;
  logic                w_valid;
  logic                w_win;
  logic                w_grant;
  logic                w_last_cyc;
  logic                w_r_en;
  logic                w_w_en;
  logic                w_ack0;
  logic                w_ack1;

  rr_arb2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (r_last),
    .gnt   (w_gnt),
    .valid (w_valid)
  );

  assign w_win      = (w_gnt == 2'b10);
  assign w_grant    = (r_state == IDLE) && w_valid;
  assign w_last_cyc = (r_cnt == c_CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, RAM enables and acks; the write enable fires only in the
  // last ACCESS cycle so the RAM sees exactly one write edge
  always_comb begin
    w_state_nxt = r_state;
    w_r_en      = 1'b0;
    w_w_en      = 1'b0;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_r_en = ~r_we;
        w_w_en = r_we & w_last_cyc;
        if (w_last_cyc) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_ack0      = (r_owner == c_PORT0);
        w_ack1      = (r_owner == c_PORT1);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transaction latch on grant, wait countdown, and per-port read capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_owner  <= c_PORT0;
      r_last   <= c_PORT1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_grant) begin
      r_we    <= w_win ? m1_we : m0_we;
      r_addr  <= (w_win ? m1_addr : m0_addr) & c_ADDR_MASK;
      r_wdata <= w_win ? m1_wdata : m0_wdata;
      r_cnt   <= c_WAIT_LOAD;
      r_owner <= w_win;
      r_last  <= w_win;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (w_last_cyc && !r_we) begin
        if (r_owner == c_PORT1) begin
          r_rdata1 <= ram_rdata;
        end else begin
          r_rdata0 <= ram_rdata;
        end
      end
    end
  end

  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_r_en  = w_r_en;
  assign ram_w_en  = w_w_en;
  assign m0_ack    = w_ack0;
  assign m1_ack    = w_ack1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign m0_stall  = m0_req & ~w_ack0;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A cycle-indexed
//                transaction model predicts every output each cycle; directed
//                scenarios are followed by randomized traffic with resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int W  = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack, m0_stall, ram_r_en, ram_w_en, busy;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_ack    (m0_ack),
    .m1_ack    (m1_ack),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .m0_stall  (m0_stall),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_r_en  (ram_r_en),
    .ram_w_en  (ram_w_en),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-word RAM attached to the DUT
  logic [DW-1:0] mem [16];
  assign ram_rdata = mem[ram_addr[5:2]];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr[5:2]] <= ram_wdata;
  end

  // Reference model: p = 0 idle, 1..W access cycle number, W+1 ack cycle
  int            p;
  logic          e_owner, e_last, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdata [2];
  logic [DW-1:0] shadow [16];

  int checks = 0;
  int errors = 0;
  int wen_seen = 0;
  int ack0_seen = 0;
  int ack1_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p          = 0;
    e_owner    = 1'b0;
    e_last     = 1'b1;
    e_we       = 1'b0;
    e_addr     = '0;
    e_wdata    = '0;
    e_rdata[0] = '0;
    e_rdata[1] = '0;
  endtask

  task automatic check_outputs();
    logic acc, resp;
    acc  = (p >= 1) && (p <= W);
    resp = (p == W + 1);
    chk("busy",      busy,      p != 0);
    chk("ram_r_en",  ram_r_en,  acc && !e_we);
    chk("ram_w_en",  ram_w_en,  (p == W) && e_we);
    chk("ram_addr",  ram_addr,  e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("m0_ack",    m0_ack,    resp && !e_owner);
    chk("m1_ack",    m1_ack,    resp && e_owner);
    chk("m0_rdata",  m0_rdata,  e_rdata[0]);
    chk("m1_rdata",  m1_rdata,  e_rdata[1]);
    chk("m0_stall",  m0_stall,  m0_req && !(resp && !e_owner));
    if (ram_w_en) wen_seen++;
    if (m0_ack) ack0_seen++;
    if (m1_ack) ack1_seen++;
  endtask

  // Advance the model across the coming clock edge using the current inputs
  task automatic model_step();
    logic win;
    if ((p == W) && e_we) shadow[e_addr[5:2]] = e_wdata;
    if (!rst_n) begin
      model_reset();
    end else if (p == 0) begin
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
          win = 1'b0;
`else
          win = ~e_last;
`endif
        end else begin
          win = m1_req;
        end
        e_owner = win;
        e_last  = win;
        e_we    = win ? m1_we : m0_we;
        e_addr  = (win ? m1_addr : m0_addr) & ~32'h3;
        e_wdata = win ? m1_wdata : m0_wdata;
        p       = 1;
      end
    end else if (p <= W) begin
      if ((p == W) && !e_we) e_rdata[e_owner] = shadow[e_addr[5:2]];
      p++;
    end else begin
      p = 0;
    end
  endtask

  task automatic step(input logic rn,
                      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst_n    = rn;
    m0_req   = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req   = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int n;
  int a0_base, a1_base, w_base;

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
    end
    mem[4] = 32'd5;
    for (int i = 0; i < 16; i++) shadow[i] = mem[i];
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    idle();
    idle();

    // Single read of 0x10 by m0, held until ack
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("read_r_en_t1", ram_r_en, 1'b1);
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("read_ack", m0_ack, 1'b1);
    chk("read_rdata", m0_rdata, 32'd5);
    idle();

    // Single write by m1, then read back by m0
    w_base = wen_seen;
    for (int i = 0; i < W + 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hDEADBEEF);
    chk("write_ack", m1_ack, 1'b1);
    chk("write_one_edge", wen_seen - w_base, 1);
    idle();
    for (int i = 0; i < W + 2; i++) step(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("readback", m0_rdata, 32'hDEADBEEF);
    idle();

    // Tie: both request continuously for four transaction slots
    a0_base = ack0_seen; a1_base = ack1_seen;
    for (int i = 0; i < 4 * (W + 2); i++) step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    chk("tie_m0_acks", ack0_seen - a0_base, 4);
    chk("tie_m1_acks", ack1_seen - a1_base, 0);
`else
    chk("tie_m0_acks", ack0_seen - a0_base, 2);
    chk("tie_m1_acks", ack1_seen - a1_base, 2);
`endif
    idle();

    // Unaligned read, request dropped during ACCESS
    a0_base = ack0_seen;
    step(1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("unaligned_addr", ram_addr, 32'h10);
    for (int i = 0; i < W; i++) idle();
    chk("drop_ack", ack0_seen - a0_base, 1);
    idle();

    // Reset during ACCESS of a read of 0x24
    a0_base = ack0_seen;
    step(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_r_en", ram_r_en, 1'b0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    for (int i = 0; i < W + 1; i++) idle();
    chk("rst_no_ack", ack0_seen - a0_base, 0);

    // Stall window for a held m0 read
    n = 0;
    for (int i = 0; i < W + 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (m0_stall) n++;
    end
    chk("stall_cycles", n, W + 1);
    chk("stall_low_at_ack", m0_stall, 1'b0);
    idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 60) != 0,
           ($urandom % 10) < 6, $urandom % 2, $urandom & 32'h3F, $urandom,
           ($urandom % 10) < 6, $urandom % 2, $urandom & 32'h3F, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port word-addressed data RAM. Sits between the pipeline MEM stage (port 0) and a secondary master such as a loader or debug port (port 1) on one side, and the data RAM on the other. Grants one transaction at a time and holds the RAM enables for a fixed number of wait cycles. Returns read data and a one-cycle acknowledge to the winner. The MEM stage uses `m0_stall` to freeze the pipeline while its access is outstanding.

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `ADDR_W`, 32: byte address width.
- `WAIT_CYCLES`, 1: cycles the RAM enables are held per access; legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `m0_req`, `m1_req`  in  1: transaction request; held until ack.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W: byte address; bits [1:0] ignored.
- `m0_wdata`, `m1_wdata`  in  DATA_W: write data.
- `m0_ack`, `m1_ack`  out  1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_W: registered read data, valid in the ack cycle.
- `m0_stall`  out  1: `m0_req & ~m0_ack`, combinational.
- `ram_addr`  out  ADDR_W: word-aligned address to the RAM, low two bits 0.
- `ram_wdata`  out  DATA_W: write data to the RAM.
- `ram_r_en`, `ram_w_en`  out  1: RAM read and write enables.
- `ram_rdata`  in  DATA_W: combinational RAM read data.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE**
  - If no request is present, remain in IDLE.
  - Otherwise pick a winner and latch its `we`, `addr` and `wdata`.
  - Load `cnt = WAIT_CYCLES`, record the winner in `owner`, and go to ACCESS.
- **ACCESS**
  - `ram_addr` and `ram_wdata` are driven from the latched values.
  - Read: `ram_r_en` = 1 for every ACCESS cycle.
  - Write: `ram_w_en` = 1 only when `cnt == 1`, giving exactly one write edge.
  - `cnt` decrements each cycle.
  - When `cnt == 1`: latch `ram_rdata` into the owner's rdata register (reads only), then go to RESP.
- **RESP**
  - The owner's ack = 1 for exactly this cycle; the other port's ack = 0.
  - Go to IDLE.
- **Arbitration (default, round-robin):**
  - If both ports request, grant the port not granted last.
  - If only one port requests, it wins.
  - `last` is updated on every grant.
- **Latched transaction:**
  - Requests, addresses and data on the ports are ignored outside IDLE.
  - A requester dropping `req` mid-transaction does not abort it; ack still pulses.
- **Rdata hold:** each port's rdata register holds its value until that port's next read completes; writes leave it unchanged.
- **Outputs in IDLE and RESP:** RAM enables are 0; `ram_addr` and `ram_wdata` hold their last latched values.

## Timing
- **Reset values:**
  - Outputs: acks 0, rdata 0, RAM enables 0, `ram_addr` 0, `ram_wdata` 0, `busy` 0.
  - Internal: state IDLE, `cnt` 0, `last` = port 1 (so port 0 wins the first tie).
- **Latency:** request sampled in IDLE at cycle t gives ACCESS in t+1..t+W and ack in t+W+1, where W = `WAIT_CYCLES`. The earliest next grant is at t+W+2.
- **Handshake:** a requester may keep `req` high in its ack cycle. It must drop `req` in the following cycle, unless it is issuing a new transaction.
- **Back-to-back from one port** while the other port is idle: one transaction every W+2 cycles.
- **Reset mid-operation:**
  - `rst_n` low at any edge returns the block to IDLE and clears the acks; the in-flight transaction is abandoned with no ack.
  - A reset sampled in the final ACCESS cycle of a write does not suppress that cycle's RAM write.
- **Out-of-range values:** `WAIT_CYCLES` outside 1..15 is a configuration error, flagged by a simulation-only check at elaboration.

## Configuration
- `MEM_ARBITER_FIXED_PRIO_EN`
  - Defined: port 0 always wins a tie, `last` is unused, and port 1 can starve.
  - Undefined: round-robin arbitration as above.

## Structure
- Package `mem_arbiter_pkg` holds:
  - the state encoding (IDLE=0, ACCESS=1, RESP=2);
  - the `cnt` width constant (4);
  - port index constants (0, 1).
- Sub-module `rr_arb2` is a combinational 2-way picker:
  - inputs: `req[1:0]`, `last`;
  - outputs: `gnt[1:0]` (one-hot) and `valid`;
  - it also implements the fixed-priority variant under the macro.

## Test plan
- **Single read:** W=1, RAM word 0x10 = 5; m0 read 0x10 at t=0 → `ram_r_en` high at t=1, `m0_ack` and `m0_rdata` = 5 at t=2.
- **Single write:** W=3; m1 writes 0xDEADBEEF to 0x24 → `ram_w_en` high in exactly one cycle, t=3; `m1_ack` at t=4; a later read of 0x24 returns 0xDEADBEEF.
- **Tie:** both ports request continuously after reset, W=1 → grants alternate m0, m1, m0, m1, one ack every 3 cycles. With the macro defined, only m0 is acked.
- **Unaligned and drop:** m0 reads 0x13 → `ram_addr` = 0x10. m0 drops `req` during ACCESS → `m0_ack` still pulses at t+W+1.
- **Reset mid-read:** `rst_n` low during ACCESS of a read → next cycle is IDLE, no ack, RAM enables 0, and `m0_rdata` is reset to 0.
- **Stall:** m0 read W=2 → `m0_stall` is high for cycles t..t+2 and low at t+3 (the ack cycle).
